// File: rtl/prio_enc_arb_if.sv
// Request/result bundle for the priority-encoder arbiter.
// The requester side is master; the arbiter side is slave.
interface prio_enc_arb_if #(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N)
) ();
    logic            enable;
    logic [N-1:0]    req;
    logic            ready;
    logic [IDXW-1:0] idx;
    logic [N-1:0]    grant;
    logic            valid;
    logic            none;

    modport master (
        output enable, req, ready,
        input  idx, grant, valid, none
    );

    modport slave (
        input  enable, req, ready,
        output idx, grant, valid, none
    );
endinterface

// File: rtl/prio_enc_arb.sv
// Registered priority encoder / arbiter, fixed or round-robin.
// Holds one result until the consumer takes it with ready.
module prio_enc_arb #(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N),
    parameter int RR   = 0
) (
    input logic          clk,
    input logic          rst,
    prio_enc_arb_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] win;
    logic            found;
    logic            load;
    logic            capture;
    int              j;

    assign load    = (state == IDLE) || bus.ready;
    assign capture = load && bus.enable && (|bus.req);

    // Search starts at ptr (0 for fixed priority) and wraps at N,
    // so non-power-of-two N never yields an out-of-range index.
    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (RR != 0) ? int'(ptr) + k : k;
            if (j >= N) j = j - N;
            if (!found && bus.req[j]) begin
                found = 1'b1;
                win   = IDXW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus.valid <= 1'b0;
            bus.grant <= '0;
            bus.idx   <= '0;
            bus.none  <= 1'b0;
            ptr       <= '0;
        end else begin
            bus.none <= load && bus.enable && !(|bus.req);
            if (load) begin
                if (capture) begin
                    state     <= HOLD;
                    bus.valid <= 1'b1;
                    bus.idx   <= win;
                    bus.grant <= {{(N-1){1'b0}}, 1'b1} << win;
                    if (RR != 0) begin
                        ptr <= (win == IDXW'(N-1)) ? '0 : win + 1'b1;
                    end
                end else begin
                    state     <= IDLE;
                    bus.valid <= 1'b0;
                    bus.grant <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_prio_enc_arb.sv
// Directed scoreboard bench for prio_enc_arb: fixed N=8,
// round-robin N=8 and round-robin N=5 instances.
module tb_prio_enc_arb;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prio_enc_arb_if #(.N(8)) bus_a ();
    prio_enc_arb_if #(.N(8)) bus_b ();
    prio_enc_arb_if #(.N(5)) bus_c ();

    prio_enc_arb #(.N(8), .RR(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    prio_enc_arb #(.N(8), .RR(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
    prio_enc_arb #(.N(5), .RR(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

    typedef struct {
        string      tag;
        int         d;
        logic [7:0] idx;
        logic [7:0] grant;
        logic       valid;
        logic       none;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string tag, input string fld,
                       input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    // Queue the expectation, advance one edge, then score the popped entry.
    task automatic step(input int d, input string tag,
                        input logic [7:0] ei, input logic [7:0] eg,
                        input logic ev, input logic en);
        exp_t       e;
        exp_t       x;
        logic [7:0] oi, og;
        logic       ov, on;
        e.tag = tag; e.d = d; e.idx = ei; e.grant = eg;
        e.valid = ev; e.none = en;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        case (x.d)
            0: begin
                oi = 8'(bus_a.idx); og = bus_a.grant;
                ov = bus_a.valid;   on = bus_a.none;
            end
            1: begin
                oi = 8'(bus_b.idx); og = bus_b.grant;
                ov = bus_b.valid;   on = bus_b.none;
            end
            default: begin
                oi = 8'(bus_c.idx); og = 8'(bus_c.grant);
                ov = bus_c.valid;   on = bus_c.none;
            end
        endcase
        cmp(x.tag, "idx", oi, x.idx);
        cmp(x.tag, "grant", og, x.grant);
        cmp(x.tag, "valid", {7'd0, ov}, {7'd0, x.valid});
        cmp(x.tag, "none", {7'd0, on}, {7'd0, x.none});
    endtask

    initial begin
        rst = 1'b1;
        bus_a.enable = 1'b0; bus_a.req = '0; bus_a.ready = 1'b0;
        bus_b.enable = 1'b0; bus_b.req = '0; bus_b.ready = 1'b0;
        bus_c.enable = 1'b0; bus_c.req = '0; bus_c.ready = 1'b0;

        // Reset state, with enable asserted to show reset wins
        bus_a.enable = 1'b1; bus_a.req = 8'hFF; bus_a.ready = 1'b1;
        step(0, "rst_a", 8'h00, 8'h00, 1'b0, 1'b0);
        step(1, "rst_b", 8'h00, 8'h00, 1'b0, 1'b0);
        step(2, "rst_c", 8'h00, 8'h00, 1'b0, 1'b0);
        bus_a.enable = 1'b0;
        rst = 1'b0;

        // Fixed priority
        bus_a.enable = 1'b1; bus_a.ready = 1'b1; bus_a.req = 8'hA4;
        step(0, "fp_a4", 8'd2, 8'h04, 1'b1, 1'b0);
        bus_a.req = 8'h80;
        step(0, "fp_80", 8'd7, 8'h80, 1'b1, 1'b0);
        bus_a.ready = 1'b0; bus_a.req = 8'h01;
        step(0, "stall1", 8'd7, 8'h80, 1'b1, 1'b0);
        bus_a.enable = 1'b0;
        step(0, "stall2", 8'd7, 8'h80, 1'b1, 1'b0);
        bus_a.enable = 1'b1;
        step(0, "stall3", 8'd7, 8'h80, 1'b1, 1'b0);
        bus_a.ready = 1'b1;
        step(0, "release", 8'd0, 8'h01, 1'b1, 1'b0);
        bus_a.req = 8'h30;
        step(0, "fp_30", 8'd4, 8'h10, 1'b1, 1'b0);
        bus_a.enable = 1'b0;
        step(0, "drain", 8'd4, 8'h00, 1'b0, 1'b0);
        bus_a.enable = 1'b1; bus_a.req = 8'h00;
        step(0, "none_hi", 8'd4, 8'h00, 1'b0, 1'b1);
        bus_a.enable = 1'b0; bus_a.req = 8'hFF;
        step(0, "none_lo", 8'd4, 8'h00, 1'b0, 1'b0);
        bus_a.enable = 1'b1;
        step(0, "fp_ff0", 8'd0, 8'h01, 1'b1, 1'b0);
        step(0, "fp_ff1", 8'd0, 8'h01, 1'b1, 1'b0);
        bus_a.enable = 1'b1; bus_a.req = 8'h00;
        step(0, "hold_none", 8'd0, 8'h00, 1'b0, 1'b1);
        bus_a.enable = 1'b0;

        // Round-robin N=8: full rotation without bubbles
        bus_b.enable = 1'b1; bus_b.ready = 1'b1; bus_b.req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step(1, $sformatf("rr8_%0d", i), 8'(i % 8),
                 8'(1 << (i % 8)), 1'b1, 1'b0);
        end
        bus_b.req = 8'h20;
        step(1, "rr8_5", 8'd5, 8'h20, 1'b1, 1'b0);
        bus_b.ready = 1'b0; bus_b.req = 8'h01;
        step(1, "rr8_hold", 8'd5, 8'h20, 1'b1, 1'b0);
        rst = 1'b1;
        step(1, "rr8_rst", 8'd0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        bus_b.ready = 1'b1; bus_b.req = 8'hFF;
        step(1, "post_rst0", 8'd0, 8'h01, 1'b1, 1'b0);
        step(1, "post_rst1", 8'd1, 8'h02, 1'b1, 1'b0);
        bus_b.req = 8'h03;
        step(1, "rr8_wrap", 8'd0, 8'h01, 1'b1, 1'b0);
        bus_b.enable = 1'b0;
        step(1, "rr8_idle", 8'd0, 8'h00, 1'b0, 1'b0);

        // Round-robin N=5: pointer wraps from 4 back to 0
        bus_c.enable = 1'b1; bus_c.ready = 1'b1; bus_c.req = 5'b10001;
        step(2, "rr5_0", 8'd0, 8'h01, 1'b1, 1'b0);
        step(2, "rr5_1", 8'd4, 8'h10, 1'b1, 1'b0);
        step(2, "rr5_2", 8'd0, 8'h01, 1'b1, 1'b0);
        step(2, "rr5_3", 8'd4, 8'h10, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/prio_enc_arb.md
PRIO_ENC_ARB -- requirements
Module: prio_enc_arb

Interface
REQ-001 Parameter N, default 8, number of request inputs; legal range 2..64, power of two not required.
REQ-002 Parameter IDXW, default $clog2(N) (3), width of the encoded index.
REQ-003 Parameter RR, default 0; 0 = fixed priority (bit 0 highest), 1 = round-robin.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  when 1, permits a new request capture.
REQ-007 req  input  N  request vector, bit i = requester i.
REQ-008 ready  input  1  downstream accepts the held result.
REQ-009 idx  output  IDXW  registered index of the winning requester.
REQ-010 grant  output  N  registered one-hot of the winner; all zero when valid=0.
REQ-011 valid  output  1  idx/grant hold a result not yet accepted.
REQ-012 none  output  1  one-cycle flag: capture attempted with req all zero.

Function
REQ-013 The block shall have two states: IDLE (no result held) and HOLD (result held, valid=1).
REQ-014 A load opportunity shall exist in a cycle when the state is IDLE, or when the state is HOLD and ready=1.
REQ-015 At a load opportunity with enable=1 and req nonzero, the block shall register the winner into idx/grant, set valid=1 and enter or stay in HOLD on the next edge. The latency from req to valid is 1 cycle.
REQ-016 At a load opportunity from HOLD with enable=0 or req=0, the block shall clear valid and grant and enter IDLE. idx shall keep its last value.
REQ-017 In HOLD with ready=0, idx, grant and valid shall remain stable regardless of req or enable changes.
REQ-018 At a load opportunity with enable=1 and req=0, none shall be 1 for exactly the following cycle; otherwise none shall be 0.
REQ-019 At a load opportunity with enable=0, nothing shall be captured and none shall stay 0.
REQ-020 For RR=0, the winner shall be the lowest-numbered set bit of req.
REQ-021 For RR=1, the block shall keep a pointer ptr (IDXW bits). The winner shall be the first set bit found searching from ptr upward, wrapping from N-1 to 0.
REQ-022 For RR=1, on each capture ptr shall become winner+1. If the winner is N-1, ptr shall wrap to 0, including when N is not a power of two. ptr shall be unchanged when there is no capture.
REQ-023 For RR=0, ptr shall be absent or constant 0 and shall have no effect.
REQ-024 With ready held at 1 and continuous requests, the block shall produce one result per cycle with no bubble cycles.
REQ-025 grant shall always equal the one-hot decode of idx whenever valid=1.
REQ-026 Request bits at index N or above shall not exist. idx shall never exceed N-1.

Reset
REQ-027 While rst=1 at a clock edge, the following shall be cleared: state=IDLE, valid=0, grant=0, idx=0, none=0, ptr=0.
REQ-028 Reset shall take priority over every other input. A result held at reset is discarded, and no capture occurs in that cycle.
REQ-029 The first capture shall be possible at the first edge after rst is deasserted.

Verification
REQ-030 RR=0, N=8: req=8'b1010_0100, enable=1, ready=1 -> next cycle idx=2, grant=8'h04, valid=1.
REQ-031 RR=0: capture req=8'h80 (idx=7), then ready=0 for 3 cycles while req=8'h01 -> idx stays 7 and valid stays 1; ready=1 -> next cycle idx=0.
REQ-032 RR=1, N=8: req=8'hFF and ready=1 held -> idx sequence 0,1,2,...,7,0 with valid=1 on every cycle.
REQ-033 RR=1, N=5: req=5'b10001 held with ready=1 -> idx alternates 0,4,0,4. This checks ptr wrap from 4 to 0.
REQ-034 enable=1, req=0 in IDLE -> none=1 for one cycle and valid=0. enable=0, req=8'hFF -> no capture and none=0.
REQ-035 From HOLD (valid=1, idx=5, RR=1, ptr=6), assert rst for one cycle -> valid=0, grant=0, idx=0, ptr=0. With req=8'hFF after reset -> idx=0.
